// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, FSM states and op classes for alu_pipe_unit
// Optional feature macro: ALU_MUL_EN (adds MUL/MULHU encodings and the MUL_RUN state).
// Encodings are packed {funct7, funct3, opcode}; '?' bits are don't-care in casez decode.
package alu_pkg;

  localparam int OP_FUNC_W = 17;

  // Register-register (opcode 0110011)
  localparam logic [OP_FUNC_W-1:0] OP_ADD   = 17'b0000000_000_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SUB   = 17'b0100000_000_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SLL   = 17'b0000000_001_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SLT   = 17'b0000000_010_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SLTU  = 17'b0000000_011_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_XOR   = 17'b0000000_100_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SRL   = 17'b0000000_101_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_SRA   = 17'b0100000_101_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_OR    = 17'b0000000_110_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_AND   = 17'b0000000_111_0110011;

  // Register-immediate (opcode 0010011); funct7 only matters for shifts
  localparam logic [OP_FUNC_W-1:0] OP_ADDI  = 17'b???????_000_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_SLTI  = 17'b???????_010_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_SLTIU = 17'b???????_011_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_XORI  = 17'b???????_100_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_ORI   = 17'b???????_110_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_ANDI  = 17'b???????_111_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_SLLI  = 17'b0000000_001_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_SRLI  = 17'b0000000_101_0010011;
  localparam logic [OP_FUNC_W-1:0] OP_SRAI  = 17'b0100000_101_0010011;

  // Address generation for loads and stores
  localparam logic [OP_FUNC_W-1:0] OP_LOAD  = 17'b???????_???_0000011;
  localparam logic [OP_FUNC_W-1:0] OP_STORE = 17'b???????_???_0100011;

  // Branch compares (opcode 1100011)
  localparam logic [OP_FUNC_W-1:0] OP_BEQ   = 17'b???????_000_1100011;
  localparam logic [OP_FUNC_W-1:0] OP_BNE   = 17'b???????_001_1100011;
  localparam logic [OP_FUNC_W-1:0] OP_BLT   = 17'b???????_100_1100011;
  localparam logic [OP_FUNC_W-1:0] OP_BGE   = 17'b???????_101_1100011;
  localparam logic [OP_FUNC_W-1:0] OP_BLTU  = 17'b???????_110_1100011;
  localparam logic [OP_FUNC_W-1:0] OP_BGEU  = 17'b???????_111_1100011;

  // Jumps
  localparam logic [OP_FUNC_W-1:0] OP_JAL   = 17'b???????_???_1101111;
  localparam logic [OP_FUNC_W-1:0] OP_JR    = 17'b???????_000_1100111;

`ifdef ALU_MUL_EN
  localparam logic [OP_FUNC_W-1:0] OP_MUL   = 17'b0000001_000_0110011;
  localparam logic [OP_FUNC_W-1:0] OP_MULHU = 17'b0000001_011_0110011;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OUT     = 2'd1
`ifdef ALU_MUL_EN
    ,
    ST_MUL_RUN = 2'd2
`endif
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_MUL     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

endpackage

// File: rtl/alu_pipe_unit_mul.sv
// rtl/alu_pipe_unit_mul.sv - iterative shift-add unsigned multiplier (alu_mul_iter)
// Ports: clk_i, rst_i (sync active-high), start_i loads operands, abort_i cancels,
//        a_i/b_i operands, busy_o while iterating, done_o on the final iteration
//        cycle, product_o = product after this cycle's iteration (full on done_o).
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     upper_sum;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;

  // Multiplier lives in the low half and shifts out one bit per cycle while
  // partial sums accumulate into the upper half (carry kept in the extra bit).
  assign upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {upper_sum, prod_q[WIDTH-1:1]};

  assign busy_o    = busy_q;
  assign done_o    = busy_q & (count_q == CNT_W'(WIDTH - 1));
  assign product_o = prod_step;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else if (start_i) begin
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
      count_q <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q  <= prod_step;
      count_q <= count_q + CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_unit.sv
// rtl/alu_pipe_unit.sv - registered, handshaked integer ALU functional unit
// Optional feature macro: ALU_MUL_EN (iterative MUL/MULHU; otherwise those are illegal).
// Ports: clk_i, rst_i (sync active-high); issue side valid_i/ready_o with
//        oprand1_i, oprand2_i, op_func_i, tag_i; flush_i squashes in-flight work;
//        result side valid_o/ready_i with result_o, tag_o, illegal_o.
module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int OPRAND_WIDTH  = 32,
  parameter int OP_FUNC_WIDTH = 17,
  parameter int IMM_WIDTH     = 12,
  parameter int TAG_WIDTH     = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [OPRAND_WIDTH-1:0]  oprand1_i,
  input  logic [OPRAND_WIDTH-1:0]  oprand2_i,
  input  logic [OP_FUNC_WIDTH-1:0] op_func_i,
  input  logic [TAG_WIDTH-1:0]     tag_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [OPRAND_WIDTH-1:0]  result_o,
  output logic [TAG_WIDTH-1:0]     tag_o,
  output logic                     illegal_o
);

  localparam int SH_W = $clog2(OPRAND_WIDTH);

  state_e                  state_q, state_d, start_state;
  op_class_e               op_class;
  logic                    accept;
  logic [OPRAND_WIDTH-1:0] imm_sext;
  logic [OPRAND_WIDTH-1:0] alu_result;
  logic [SH_W-1:0]         shamt;
  logic [OPRAND_WIDTH-1:0] result_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic                    illegal_q;

  assign imm_sext = {{(OPRAND_WIDTH-IMM_WIDTH){oprand2_i[IMM_WIDTH-1]}}, oprand2_i[IMM_WIDTH-1:0]};
  assign shamt    = oprand2_i[SH_W-1:0];

`ifdef ALU_MUL_EN
  logic                      mul_hi, mul_hi_q;
  logic                      mul_busy, mul_done;
  logic [2*OPRAND_WIDTH-1:0] mul_product;
`endif

  // Operation decode and single-cycle datapath
  always_comb begin
    alu_result = '0;
    op_class   = CLS_ALU;
`ifdef ALU_MUL_EN
    mul_hi     = 1'b0;
`endif
    casez (op_func_i)
      OP_ADD:   alu_result = oprand1_i + oprand2_i;
      OP_SUB:   alu_result = oprand1_i - oprand2_i;
      OP_SLL:   alu_result = oprand1_i << shamt;
      OP_SLT:   alu_result[0] = $signed(oprand1_i) < $signed(oprand2_i);
      OP_SLTU:  alu_result[0] = oprand1_i < oprand2_i;
      OP_XOR:   alu_result = oprand1_i ^ oprand2_i;
      OP_SRL:   alu_result = oprand1_i >> shamt;
      OP_SRA:   alu_result = OPRAND_WIDTH'($signed(oprand1_i) >>> shamt);
      OP_OR:    alu_result = oprand1_i | oprand2_i;
      OP_AND:   alu_result = oprand1_i & oprand2_i;
      OP_ADDI:  alu_result = oprand1_i + imm_sext;
      OP_SLTI:  alu_result[0] = $signed(oprand1_i) < $signed(imm_sext);
      OP_SLTIU: alu_result[0] = oprand1_i < imm_sext;
      OP_XORI:  alu_result = oprand1_i ^ imm_sext;
      OP_ORI:   alu_result = oprand1_i | imm_sext;
      OP_ANDI:  alu_result = oprand1_i & imm_sext;
      OP_SLLI:  alu_result = oprand1_i << shamt;
      OP_SRLI:  alu_result = oprand1_i >> shamt;
      OP_SRAI:  alu_result = OPRAND_WIDTH'($signed(oprand1_i) >>> shamt);
      OP_LOAD:  alu_result = oprand1_i + imm_sext;
      OP_STORE: alu_result = oprand1_i + imm_sext;
      OP_BEQ:   alu_result[0] = oprand1_i == oprand2_i;
      OP_BNE:   alu_result[0] = oprand1_i != oprand2_i;
      OP_BLT:   alu_result[0] = $signed(oprand1_i) < $signed(oprand2_i);
      OP_BGE:   alu_result[0] = $signed(oprand1_i) >= $signed(oprand2_i);
      OP_BLTU:  alu_result[0] = oprand1_i < oprand2_i;
      OP_BGEU:  alu_result[0] = oprand1_i >= oprand2_i;
      OP_JAL:   alu_result = oprand1_i + OPRAND_WIDTH'(1);
      OP_JR:    alu_result = '0;
`ifdef ALU_MUL_EN
      OP_MUL:   op_class = CLS_MUL;
      OP_MULHU: begin
        op_class = CLS_MUL;
        mul_hi   = 1'b1;
      end
`endif
      default:  op_class = CLS_ILLEGAL;
    endcase
  end

  // FSM next state and issue-side handshake
  always_comb begin
    state_d     = state_q;
    start_state = ST_OUT;
`ifdef ALU_MUL_EN
    if (op_class == CLS_MUL) begin
      start_state = ST_MUL_RUN;
    end
`endif
    ready_o = ((state_q == ST_IDLE) || ((state_q == ST_OUT) && ready_i)) && !flush_i;
    accept  = valid_i && ready_o;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = start_state;
        ST_OUT: begin
          if (ready_i) begin
            state_d = accept ? start_state : ST_IDLE;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL_RUN: begin
          if (mul_done) begin
            state_d = ST_OUT;
          end else if (!mul_busy) begin
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers only load on accept (or multiply completion), so they
  // hold steady while the CDB withholds ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q  <= '0;
      tag_q     <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      mul_hi_q  <= 1'b0;
`endif
    end else if (accept) begin
      result_q  <= alu_result;
      tag_q     <= tag_i;
      illegal_q <= (op_class == CLS_ILLEGAL);
`ifdef ALU_MUL_EN
      mul_hi_q  <= mul_hi;
    end else if ((state_q == ST_MUL_RUN) && mul_done && !flush_i) begin
      result_q  <= mul_hi_q ? mul_product[2*OPRAND_WIDTH-1:OPRAND_WIDTH]
                            : mul_product[OPRAND_WIDTH-1:0];
`endif
    end
  end

`ifdef ALU_MUL_EN
  alu_mul_iter #(
    .WIDTH(OPRAND_WIDTH)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (accept && (op_class == CLS_MUL)),
    .abort_i  (flush_i),
    .a_i      (oprand1_i),
    .b_i      (oprand2_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`endif

  assign valid_o   = (state_q == ST_OUT);
  assign result_o  = result_q;
  assign tag_o     = tag_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb/tb_alu_pipe_unit.sv - directed and randomized bench for alu_pipe_unit
`timescale 1ns/1ps
module tb_alu_pipe_unit;

  localparam int W  = 32;
  localparam int FW = 17;
  localparam int TW = 6;

  localparam logic [16:0] E_ADD   = 17'b0000000_000_0110011;
  localparam logic [16:0] E_SUB   = 17'b0100000_000_0110011;
  localparam logic [16:0] E_SLT   = 17'b0000000_010_0110011;
  localparam logic [16:0] E_SLTU  = 17'b0000000_011_0110011;
  localparam logic [16:0] E_XOR   = 17'b0000000_100_0110011;
  localparam logic [16:0] E_ADDI  = 17'b0000000_000_0010011;
  localparam logic [16:0] E_SRAI  = 17'b0100000_101_0010011;
  localparam logic [16:0] E_BEQ   = 17'b0000000_000_1100011;
  localparam logic [16:0] E_BLT   = 17'b0000000_100_1100011;
  localparam logic [16:0] E_BGEU  = 17'b0000000_111_1100011;
  localparam logic [16:0] E_JAL   = 17'b0000000_000_1101111;
  localparam logic [16:0] E_MUL   = 17'b0000001_000_0110011;
  localparam logic [16:0] E_MULHU = 17'b0000001_011_0110011;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_i, flush_i;
  logic [W-1:0]  oprand1_i, oprand2_i;
  logic [FW-1:0] op_func_i;
  logic [TW-1:0] tag_i;
  logic          ready_o, valid_o, illegal_o;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_pipe_unit dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .oprand1_i(oprand1_i),
    .oprand2_i(oprand2_i),
    .op_func_i(op_func_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .tag_o    (tag_o),
    .illegal_o(illegal_o)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model straight from the ISA fields.
  function automatic void model(input logic [16:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    logic [6:0]  f7, opc;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [63:0] p;
    f7 = f[16:10]; f3 = f[9:7]; opc = f[6:0];
    imm = {{20{b[11]}}, b[11:0]};
    sh = b[4:0];
    res = 32'd0; ill = 1'b0; lat = 1; p = 64'd0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: res = a + b;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = a >> sh;
            3'd6: res = a | b;
            default: res = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) res = $signed(a) >>> sh;
`ifdef ALU_MUL_EN
        else if (f7 == 7'h01 && f3 == 3'd0) begin p = {32'd0, a} * {32'd0, b}; res = p[31:0]; lat = W + 1; end
        else if (f7 == 7'h01 && f3 == 3'd3) begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; lat = W + 1; end
`endif
        else ill = 1'b1;
      end
      7'b0010011: begin
        case (f3)
          3'd0: res = a + imm;
          3'd2: res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
          3'd3: res = (a < imm) ? 32'd1 : 32'd0;
          3'd4: res = a ^ imm;
          3'd6: res = a | imm;
          3'd7: res = a & imm;
          3'd1: if (f7 == 7'h00) res = a << sh; else ill = 1'b1;
          default: begin
            if (f7 == 7'h00) res = a >> sh;
            else if (f7 == 7'h20) res = $signed(a) >>> sh;
            else ill = 1'b1;
          end
        endcase
      end
      7'b0000011, 7'b0100011: res = a + imm;
      7'b1100011: begin
        case (f3)
          3'd0: res = (a == b) ? 32'd1 : 32'd0;
          3'd1: res = (a != b) ? 32'd1 : 32'd0;
          3'd4: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd5: res = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
          3'd6: res = (a < b) ? 32'd1 : 32'd0;
          3'd7: res = (a >= b) ? 32'd1 : 32'd0;
          default: ill = 1'b1;
        endcase
      end
      7'b1101111: res = a + 32'd1;
      7'b1100111: if (f3 != 3'd0) ill = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  // Scoreboard: at most one operation in flight, visible from its due cycle.
  typedef struct {
    int          due;
    logic [31:0] res;
    logic [5:0]  tag;
    logic        ill;
  } exp_t;
  exp_t q[$];
  exp_t e;
  bit   vexp, rexp;
  logic [31:0] m_res;
  logic        m_ill;
  int          m_lat;

  always @(negedge clk) begin
    if (rst_i) begin
      q.delete();
    end else begin
      vexp = (q.size() > 0) && (cycle >= q[0].due);
      rexp = !flush_i && ((q.size() == 0) || (vexp && ready_i));
      check_eq("mon_valid", valid_o, vexp);
      check_eq("mon_ready", ready_o, rexp);
      if (vexp) begin
        check_eq("mon_result", result_o, q[0].res);
        check_eq("mon_tag", tag_o, q[0].tag);
        check_eq("mon_illegal", illegal_o, q[0].ill);
      end
      if (flush_i) begin
        q.delete();
      end else begin
        if (vexp && ready_i) void'(q.pop_front());
        if (valid_i && rexp) begin
          model(op_func_i, oprand1_i, oprand2_i, m_res, m_ill, m_lat);
          e.due = cycle + m_lat; e.res = m_res; e.tag = tag_i; e.ill = m_ill;
          q.push_back(e);
        end
      end
    end
  end

  task automatic do_reset(input string nm);
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_eq({nm, "_valid"}, valid_o, 0);
    check_eq({nm, "_result"}, result_o, 0);
    check_eq({nm, "_tag"}, tag_o, 0);
    check_eq({nm, "_illegal"}, illegal_o, 0);
    check_eq({nm, "_ready"}, ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string nm, input logic [16:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input logic [31:0] er, input logic eill, input int elat);
    int acc, n;
    op_func_i = f; oprand1_i = a; oprand2_i = b; tag_i = t; valid_i = 1'b1; ready_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin @(negedge clk); n++; end
    check_eq({nm, "_accept"}, ready_o, 1);
    acc = cycle;
    @(posedge clk); #1 valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 100) begin @(negedge clk); n++; end
    check_eq({nm, "_latency"}, cycle - acc, elat);
    check_eq({nm, "_result"}, result_o, er);
    check_eq({nm, "_tag"}, tag_o, t);
    check_eq({nm, "_illegal"}, illegal_o, eill);
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] pick_op(input int k);
    case (k)
      0: return 17'b0000000_000_0110011;  1: return 17'b0100000_000_0110011;
      2: return 17'b0000000_001_0110011;  3: return 17'b0000000_010_0110011;
      4: return 17'b0000000_011_0110011;  5: return 17'b0000000_100_0110011;
      6: return 17'b0000000_101_0110011;  7: return 17'b0100000_101_0110011;
      8: return 17'b0000000_110_0110011;  9: return 17'b0000000_111_0110011;
      10: return 17'b0000000_000_0010011; 11: return 17'b0000000_010_0010011;
      12: return 17'b0000000_011_0010011; 13: return 17'b0000000_100_0010011;
      14: return 17'b0000000_110_0010011; 15: return 17'b0000000_111_0010011;
      16: return 17'b0000000_001_0010011; 17: return 17'b0000000_101_0010011;
      18: return 17'b0100000_101_0010011; 19: return 17'b0000000_010_0000011;
      20: return 17'b0000000_010_0100011; 21: return 17'b0000000_000_1100011;
      22: return 17'b0000000_001_1100011; 23: return 17'b0000000_100_1100011;
      24: return 17'b0000000_101_1100011; 25: return 17'b0000000_110_1100011;
      26: return 17'b0000000_111_1100011; 27: return 17'b0000000_000_1101111;
      28: return 17'b0000000_000_1100111; 29: return 17'b0000001_000_0110011;
      default: return 17'b0000001_011_0110011;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int   pick;
    logic [16:0] f;
    bit   seen;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    oprand1_i = '0; oprand2_i = '0; op_func_i = '0; tag_i = '0;

    do_reset("reset");

    run_op("add",   E_ADD,  32'd7, 32'hFFFF_FFFD, 6'd5, 32'd4, 1'b0, 1);
    run_op("sub",   E_SUB,  32'd0, 32'd1, 6'd6, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("addi",  E_ADDI, 32'h10, 32'h0000_0FFF, 6'd7, 32'hF, 1'b0, 1);
    run_op("srai",  E_SRAI, 32'h8000_0000, 32'd4, 6'd8, 32'hF800_0000, 1'b0, 1);
    run_op("sltu",  E_SLTU, 32'd1, 32'hFFFF_FFFF, 6'd9, 32'd1, 1'b0, 1);
    run_op("slt",   E_SLT,  32'd1, 32'hFFFF_FFFF, 6'd10, 32'd0, 1'b0, 1);
    run_op("blt",   E_BLT,  32'hFFFF_FFFF, 32'd1, 6'd11, 32'd1, 1'b0, 1);
    run_op("bgeu",  E_BGEU, 32'hFFFF_FFFF, 32'd1, 6'd12, 32'd1, 1'b0, 1);
    run_op("beq",   E_BEQ,  32'd5, 32'd6, 6'd13, 32'd0, 1'b0, 1);
    run_op("jal",   E_JAL,  32'h100, 32'd0, 6'd14, 32'h101, 1'b0, 1);
    run_op("illeg", 17'h1FFFF, 32'd3, 32'd4, 6'd15, 32'd0, 1'b1, 1);
`ifdef ALU_MUL_EN
    run_op("mul",   E_MUL,   32'h10000, 32'h10000, 6'd16, 32'd0, 1'b0, 33);
    run_op("mulhu", E_MULHU, 32'h10000, 32'h10000, 6'd17, 32'd1, 1'b0, 33);
`else
    run_op("mul_off", E_MUL, 32'h10000, 32'h10000, 6'd16, 32'd0, 1'b1, 1);
`endif

    // Backpressure: result must hold while ready_i is low
    op_func_i = E_ADD; oprand1_i = 32'd1; oprand2_i = 32'd2; tag_i = 6'd9; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk); check_eq("bp_accept", ready_o, 1);
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_valid", valid_o, 1);
      check_eq("bp_result", result_o, 3);
      check_eq("bp_tag", tag_o, 9);
      check_eq("bp_ready", ready_o, 0);
      @(posedge clk); #1;
    end
    ready_i = 1'b1; valid_i = 1'b1; op_func_i = E_XOR; oprand1_i = 32'hF0; oprand2_i = 32'hFF; tag_i = 6'd10;
    @(negedge clk); check_eq("bp_release_ready", ready_o, 1);
    @(posedge clk); #1 valid_i = 1'b0;
    @(negedge clk);
    check_eq("bp_next_valid", valid_o, 1);
    check_eq("bp_next_result", result_o, 32'h0F);
    check_eq("bp_next_tag", tag_o, 10);
    @(posedge clk); #1;

    // Flush a stalled result; a same-cycle issue is dropped
    op_func_i = E_ADD; oprand1_i = 32'd5; oprand2_i = 32'd5; tag_i = 6'd3; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1; ready_i = 1'b1;
    @(negedge clk); check_eq("flush_ready_low", ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", valid_o, 0);
    check_eq("flush_ready", ready_o, 1);
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    op_func_i = E_MUL; oprand1_i = 32'd3; oprand2_i = 32'd5; tag_i = 6'd4; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk); check_eq("fmul_accept", ready_o, 1);
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1; valid_i = 1'b1;
    @(negedge clk); check_eq("fmul_ready_low", ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk); check_eq("fmul_ready", ready_o, 1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid_o) seen = 1'b1; end
    check_eq("fmul_never_valid", seen, 0);
    @(posedge clk); #1;
    op_func_i = E_MUL; oprand1_i = 32'd7; oprand2_i = 32'd9; valid_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`else
    op_func_i = E_ADD; oprand1_i = 32'd20; oprand2_i = 32'd22; tag_i = 6'd21; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1 valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif
    do_reset("midrst");

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 99) < 2);
      pick = $urandom_range(0, 9);
      if (pick < 7) f = pick_op($urandom_range(0, 30));
      else if (pick < 9) begin f = pick_op($urandom_range(0, 30)); f[16:7] = 10'($urandom); end
      else f = 17'($urandom);
      op_func_i = f;
      oprand1_i = rand_operand();
      oprand2_i = rand_operand();
      tag_i = 6'($urandom);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe_unit.md
# alu_pipe_unit

Registered, handshaked integer ALU functional unit for the out-of-order core: accepts one issued operation per cycle from the reservation station, returns the result with its ROB tag one cycle later, and optionally runs an iterative RV32M multiply over several cycles. It generalises the combinational ALU sub-unit with configurable width, tag passthrough, valid/ready flow control, flush, and illegal-op reporting. It sits between issue and the common data bus arbiter.

## Interface
- OPRAND_WIDTH, 32, datapath width (≥ 8, power of two)
- OP_FUNC_WIDTH, 17, packed {funct7, funct3, opcode}
- IMM_WIDTH, 12, immediate width carried in oprand2_i LSBs
- TAG_WIDTH, 6, ROB tag width
- clk_i  input  1  clock; all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  issue valid
- ready_o  output  1  unit can accept this cycle
- oprand1_i, oprand2_i  input  OPRAND_WIDTH  rs1/PC, rs2/immediate
- op_func_i  input  OP_FUNC_WIDTH  operation select
- tag_i  input  TAG_WIDTH  ROB tag
- flush_i  input  1  squash everything in flight
- valid_o  output  1  result valid
- ready_i  input  1  CDB grant
- result_o  output  OPRAND_WIDTH  result, or branch flag in bit 0
- tag_o  output  TAG_WIDTH  tag of result
- illegal_o  output  1  op_func_i matched no operation

## Operation
- Ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; loads/stores (rs1 + sext imm); BEQ BNE BLT BGE BLTU BGEU (bit0 = taken, rest 0); JAL (oprand1_i + 1); JR (result 0).
- Immediate sign-extended from bit IMM_WIDTH-1 to OPRAND_WIDTH. Shift amount = oprand2_i[$clog2(OPRAND_WIDTH)-1:0]. Add/sub wrap modulo 2^OPRAND_WIDTH.
- Unmatched op_func_i: completes normally, result_o = 0, illegal_o = 1.
- Fully combinational decode; no latches (every path assigns all signals).
- FSM: IDLE, MUL_RUN, OUT. IDLE accept of ALU op → OUT; accept of MUL op → MUL_RUN; MUL_RUN after OPRAND_WIDTH iterations → OUT; OUT with ready_i and no new accept → IDLE; OUT with ready_i and accept → OUT/MUL_RUN per new op.
- ready_o = (state == IDLE) | (state == OUT & ready_i), forced 0 while flush_i.
- valid_o = (state == OUT); result_o/tag_o/illegal_o held stable while valid_o & !ready_i.

## Timing
- Reset: state IDLE, valid_o 0, result_o 0, tag_o 0, illegal_o 0, ready_o 1 the cycle after rst_i deasserts.
- ALU latency 1: accept at cycle N → valid_o at N+1. Back-to-back throughput 1/cycle when ready_i held high.
- MUL latency OPRAND_WIDTH + 1; ready_o 0 throughout MUL_RUN.
- flush_i: next cycle state IDLE, valid_o 0, multiplier aborted; a same-cycle valid_i is dropped; flush overrides ready_i.
- rst_i mid-multiply: identical to flush plus output registers cleared.

## Configuration
- ALU_MUL_EN defined: MUL (0000001_000_0110011) and MULHU (0000001_011_0110011) supported via iterative shift-add, MUL_RUN state present.
- Undefined: those encodings are illegal (result 0, illegal_o 1, latency 1); no MUL_RUN state, no multiplier logic.

## Structure
- Package alu_pkg: op_func encodings as wildcard localparams, fsm state enum, op-class enum (ALU/MUL/ILLEGAL).
- Sub-module alu_mul_iter: start/busy/done, 2×OPRAND_WIDTH product register, OPRAND_WIDTH-cycle counter, abort input; instantiated only under ALU_MUL_EN.

## Test plan
- Reset then ADD 7 + (−3), tag 5 → next cycle valid_o 1, result 4, tag_o 5; SUB 0 − 1 → 0xFFFFFFFF.
- ADDI rs1=0x10, imm 0xFFF → 0xF; SRAI 0x80000000 by 4 → 0xF8000000; SLTU 1 vs 0xFFFFFFFF → 1, SLT → 0.
- BLT −1 vs 1 → bit0 1; BGEU −1 vs 1 → 1; BEQ 5 vs 6 → 0.
- Backpressure: ready_i 0 for 3 cycles after ADD result → valid_o/result stable, ready_o 0; release → next op accepted same cycle.
- ALU_MUL_EN: MUL 0x10000 × 0x10000 → 0 after 33 cycles; MULHU same → 1; flush at cycle 10 → valid_o never asserts, ready_o 1 next cycle.
- op_func_i 17'h1FFFF → illegal_o 1, result 0; without ALU_MUL_EN, MUL → illegal_o 1 at latency 1.
